// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM states, the ALU opcodes it
// issues, and the divide-operation encodings.
package alu_div_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_CMP   = 3'd3,
    ST_SUB   = 3'd4,
    ST_FIX   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0100;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Restoring shift-subtract divider that borrows the parent's ALU for every add,
// subtract and compare. Optional macro ALU_DIV_SEQ_EARLY_OUT_EN short-cuts b=0.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] res_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_res_i
);

  state_e          r_state;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_sign_a;
  logic            r_sign_b;
  logic            r_b_zero;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_q;
  logic [5:0]      r_cnt;
  logic            r_lt;
  logic [XLEN-1:0] r_res;

  logic            w_dbit;
  logic [XLEN-1:0] w_rs;
  logic            w_take;
  logic            w_neg;
  logic [XLEN-1:0] w_sel;

  assign w_dbit = |(r_a & ({{(XLEN-1){1'b0}}, 1'b1} << r_cnt));
  assign w_rs   = {r_rem[XLEN-2:0], w_dbit};
  // A set bit shifted out of R means Rs >= D regardless of the 32-bit compare.
  assign w_take = r_rem[XLEN-1] | ~r_lt;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_sel = r_q;
    w_neg = 1'b0;
    case (r_op)
      OP_DIV:  w_neg = (r_sign_a ^ r_sign_b) & ~r_b_zero;
      OP_DIVU: w_sel = r_q;
      OP_REM:  begin w_sel = r_rem; w_neg = r_sign_a; end
      OP_REMU: w_sel = r_rem;
      default: w_sel = r_q;
    endcase
  end

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = ALU_ADD;
    case (r_state)
      ST_ABS_A: begin alu_b_o = r_a;   alu_op_o = ALU_SUB;  end
      ST_ABS_B: begin alu_b_o = r_b;   alu_op_o = ALU_SUB;  end
      ST_CMP:   begin alu_a_o = w_rs;  alu_b_o = r_b; alu_op_o = ALU_SLTU; end
      ST_SUB:   begin alu_a_o = w_rs;  alu_b_o = r_b; alu_op_o = ALU_SUB;  end
      ST_FIX:   begin alu_b_o = w_sel; alu_op_o = ALU_SUB;  end
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_DIV;
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_lt     <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_op     <= op_i;
          r_a      <= a_i;
          r_b      <= b_i;
          r_sign_a <= a_i[XLEN-1] & is_signed_op(op_i);
          r_sign_b <= b_i[XLEN-1] & is_signed_op(op_i);
          r_b_zero <= (b_i == '0);
`ifdef ALU_DIV_SEQ_EARLY_OUT_EN
          if (b_i == '0) begin
            r_res   <= ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_ABS_A;
          end
`else
          r_state <= ST_ABS_A;
`endif
        end
        ST_ABS_A: begin
          if (r_sign_a) r_a <= alu_res_i;
          r_state <= ST_ABS_B;
        end
        ST_ABS_B: begin
          if (r_sign_b) r_b <= alu_res_i;
          r_rem   <= '0;
          r_q     <= '0;
          r_cnt   <= 6'(XLEN - 1);
          r_state <= ST_CMP;
        end
        ST_CMP: begin
          r_lt    <= alu_res_i[0];
          r_state <= ST_SUB;
        end
        ST_SUB: begin
          r_rem <= w_take ? alu_res_i : w_rs;
          r_q   <= {r_q[XLEN-2:0], w_take};
          if (r_cnt == 6'd0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt   <= r_cnt - 6'd1;
            r_state <= ST_CMP;
          end
        end
        ST_FIX: begin
          r_res   <= w_neg ? alu_res_i : w_sel;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);
  assign res_o  = r_res;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: vector table plus scoreboard, with an
// ALU model standing in for the parent stage's ALU.
module tb_alu_div_seq;
  import alu_div_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] res_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_res_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];

  alu_div_seq #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o), .res_o(res_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    case (alu_op_o)
      4'b0000: alu_res_i = alu_a_o + alu_b_o;
      4'b0001: alu_res_i = alu_a_o - alu_b_o;
      4'b0100: alu_res_i = {31'b0, alu_a_o < alu_b_o};
      default: alu_res_i = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation at edge 0, wait for done, then score result and latency.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold_start);
    int  lat;
    bit  seen;
    int  exp_lat;
    logic [31:0] want;
`ifdef ALU_DIV_SEQ_EARLY_OUT_EN
    exp_lat = (b == 0) ? 0 : 67;
`else
    exp_lat = 67;
`endif
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    sb_q.push_back(exp);
    @(posedge clk_i);
    #1;
    if (!hold_start) start_i = 1'b0;
    lat  = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (k == 0) check({name, " busy"}, 32'(busy_o), 32'd1);
      if (done_o) begin seen = 1; break; end
      @(posedge clk_i);
      lat++;
    end
    want = sb_q.pop_front();
    if (!seen) begin
      check({name, " timeout"}, 32'(seen), 32'd1);
    end else begin
      check({name, " res"}, res_o, want);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " done alu"}, {alu_a_o[15:0] | alu_b_o[15:0], 12'h0, alu_op_o}, 32'h0);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      @(negedge clk_i);
      check({name, " done pulse"}, {31'b0, done_o}, 32'd0);
      check({name, " idle"}, {31'b0, busy_o}, 32'd0);
      check({name, " held"}, res_o, want);
    end
  endtask

  initial begin
    bit saw_done;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'h0000_000E});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'h0000_0002});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001});
    vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000});
    vecs.push_back('{OP_DIVU, 32'h0000_1234,  32'h0,          32'hFFFF_FFFF});
    vecs.push_back('{OP_REMU, 32'h0000_1234,  32'h0,          32'h0000_1234});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'h0,          32'hFFFF_FFFF});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'h0,          32'hFFFF_FFFB});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.op  = 2'($urandom_range(0, 3));
      v.a   = $urandom;
      v.b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      v.exp = ref_div(v.op, v.a, v.b);
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset done", {31'b0, done_o}, 32'd0);
    check("reset res", res_o, 32'd0);
    check("reset alu", alu_a_o | alu_b_o | {28'b0, alu_op_o}, 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

    // start_i held high through the whole operation including DONE: no restart.
    run_op("hold_start", OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1);

    // Ignored second start at edge 10, reset at edge 30 aborts without done.
    @(negedge clk_i);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    saw_done = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk_i);
      #1;
      if (done_o) saw_done = 1;
      if (e == 9)  begin start_i = 1'b1; a_i = 32'd50; b_i = 32'd5; end
      if (e == 10) start_i = 1'b0;
      if (e == 20) check("busy mid-flight", {31'b0, busy_o}, 32'd1);
      if (e == 29) rst_i = 1'b1;
    end
    rst_i = 1'b0;
    check("abort busy", {31'b0, busy_o}, 32'd0);
    check("abort res", res_o, 32'd0);
    check("abort no done", {31'b0, saw_done}, 32'd0);
    check("abort alu", alu_a_o | alu_b_o | {28'b0, alu_op_o}, 32'd0);
    run_op("after_abort", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd8; b_i = 32'd2;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; start_i = 1'b0;
    check("rst priority busy", {31'b0, busy_o}, 32'd0);
    check("rst priority res", res_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; SHALL be 32 when paired with the ALU.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request; accepted only in IDLE.
REQ-005 op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
REQ-006 a_i / b_i  input  32 each  dividend / divisor; sampled with start_i.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 done_o  output  1  one-cycle completion pulse.
REQ-009 res_o  output  32  result; held until the next accepted start.
REQ-010 alu_a_o / alu_b_o  output  32 each  ALU operands.
REQ-011 alu_op_o  output  4  ALU opcode: 0000 ADD, 0001 SUB, 0100 SLTU.
REQ-012 alu_res_i  input  32  ALU result, combinational from the alu_* outputs.

Function
REQ-013 States SHALL be IDLE, ABS_A, ABS_B, CMP, SUB, FIX, DONE.
REQ-014 IDLE: start_i=1 SHALL latch op_i, a_i and b_i (the sampling edge is edge 0) and go to ABS_A; otherwise stay.
REQ-015 ABS_A / ABS_B: signed ops with a negative operand SHALL use ALU SUB(0, x) to store |x|; otherwise the operand SHALL be stored unchanged; each state SHALL last one cycle always.
REQ-016 The remainder register R (32b) SHALL clear to 0 on entry to the loop, and a 6-bit counter SHALL run 31 down to 0.
REQ-017 CMP: form Rs = {R[30:0], dividend[bit]}, keep c = R[31], and drive SLTU(Rs, D).
REQ-018 SUB: if c=1 or the SLTU result is 0, then R SHALL become SUB(Rs, D) (mod 2^32) and q[bit] SHALL be 1; otherwise R SHALL become Rs and q[bit] SHALL be 0.
REQ-019 SUB with bit=0 SHALL go to FIX; otherwise it SHALL go to CMP with bit-1.
REQ-020 FIX: quotient SHALL be negated via SUB(0,q) iff op=DIV, sign(a) differs from sign(b), and b is nonzero.
REQ-021 FIX: remainder SHALL be negated iff op=REM and a is negative.
REQ-022 FIX: the selected value SHALL be registered into res_o.
REQ-023 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-024 Latency: done_o SHALL be high between edge 67 and edge 68, independent of operands (except REQ-033).
REQ-025 start_i in any state other than IDLE (including DONE) SHALL be ignored, with no effect on the operation in flight.
REQ-026 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to a.
REQ-027 0x80000000 / 0xFFFFFFFF (DIV/REM) SHALL give 0x80000000 / 0.
REQ-028 IDLE and DONE SHALL drive alu_a_o=0, alu_b_o=0, alu_op_o=0000.

Reset
REQ-029 rst_i=1 at any edge SHALL force IDLE, busy_o=0, done_o=0, res_o=0, alu_a_o=0, alu_b_o=0, alu_op_o=0000, and counter/R/q=0.
REQ-030 Reset mid-operation SHALL abort without a done_o pulse.
REQ-031 rst_i SHALL take priority over start_i in the same cycle.

Configuration
REQ-032 Macro ALU_DIV_SEQ_EARLY_OUT_EN.
REQ-033 Defined: a start with b_i=0 SHALL go IDLE->DONE at edge 0 with the REQ-026 result in res_o, so done_o is high between edge 0 and edge 1.
REQ-034 Undefined: b_i=0 SHALL take the full 68-cycle path and produce the same result.

Structure
REQ-035 Package alu_div_seq_pkg SHALL hold the state enum, the ALU opcode constants (ADD/SUB/SLTU) and the op_i encodings.
REQ-036 No sub-module; the ALU instance SHALL live in the parent stage and connect through the alu_* ports.

Verification
REQ-037 DIVU 100/7 -> res_o=0x0000000E; done_o high between edge 67 and edge 68; busy_o high from edge 0 to edge 68.
REQ-038 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-039 DIVU 0xFFFFFFFF/0x80000001 -> 0x00000001; REMU -> 0x7FFFFFFE (exercises the c=1 path).
REQ-040 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234, latency 68 cycles without the macro and 1 cycle with it.
REQ-041 Start DIVU 9/3, second start_i at edge 10 ignored, rst_i at edge 30 -> IDLE with busy_o=0, res_o=0 and no done_o; new start then -> correct result.
